jpeg_enc_quant: RTL

JPEG_ENC_QUANT -- requirements
Module: jpeg_enc_quant

---
 rtl/jpeg_enc_quant_pkg.sv | 59 +++++
 rtl/jpeg_enc_quant_if.sv | 33 +++
 rtl/jpeg_enc_qtab.sv | 22 ++
 rtl/jpeg_enc_quant.sv | 138 +++++++++++++
 4 files changed

// File: rtl/jpeg_enc_quant_pkg.sv
// Shared types, widths and tables for the JPEG quantizer: FSM states, zigzag order and
// quality-50 Annex K quantization tables (natural row-major order).
package jpeg_enc_quant_pkg;

    localparam int unsigned COEF_W  = 18;
    localparam int unsigned QOUT_W  = 12;
    localparam int unsigned RECIP_W = 16;
    localparam int unsigned IDX_W   = 6;
    localparam int unsigned QMAX    = 2047;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StExit
    } state_e;

    // Zigzag position -> natural index.
    localparam logic [IDX_W-1:0] ZZ [64] = '{
         0,  1,  8, 16,  9,  2,  3, 10,
        17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34,
        27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36,
        29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46,
        53, 60, 61, 54, 47, 55, 62, 63
    };

    localparam int unsigned Q_LUMA [64] = '{
        16,  11,  10,  16,  24,  40,  51,  61,
        12,  12,  14,  19,  26,  58,  60,  55,
        14,  13,  16,  24,  40,  57,  69,  56,
        14,  17,  22,  29,  51,  87,  80,  62,
        18,  22,  37,  56,  68, 109, 103,  77,
        24,  35,  55,  64,  81, 104, 113,  92,
        49,  64,  78,  87, 103, 121, 120, 101,
        72,  92,  95,  98, 112, 100, 103,  99
    };

    localparam int unsigned Q_CHROMA [64] = '{
        17,  18,  24,  47,  99,  99,  99,  99,
        18,  21,  26,  66,  99,  99,  99,  99,
        24,  26,  56,  99,  99,  99,  99,  99,
        47,  66,  99,  99,  99,  99,  99,  99,
        99,  99,  99,  99,  99,  99,  99,  99,
        99,  99,  99,  99,  99,  99,  99,  99,
        99,  99,  99,  99,  99,  99,  99,  99,
        99,  99,  99,  99,  99,  99,  99,  99
    };

    // round(65536 / q); only ever evaluated on constants at elaboration.
    function automatic logic [RECIP_W-1:0] recip_of(input int unsigned q);
        int unsigned r;
        r = (32'd65536 + q / 2) / q;
        return r[RECIP_W-1:0];
    endfunction

endpackage

// File: rtl/jpeg_enc_quant_if.sv
// Block-level bus of the quantizer: start/done handshake plus the dctdu read and qdu write ports.
interface jpeg_enc_quant_if;
    import jpeg_enc_quant_pkg::*;

    logic                      s_conv;
    logic [IDX_W-1:0]          dctdu_ram_ar;
    logic signed [COEF_W-1:0]  dctdu_ram_di;
    logic [IDX_W-1:0]          qdu_ram_aw;
    logic                      qdu_ram_we;
    logic signed [QOUT_W-1:0]  qdu_ram_do;
    logic                      e_conv;

    modport slave (
        input  s_conv,
        input  dctdu_ram_di,
        output dctdu_ram_ar,
        output qdu_ram_aw,
        output qdu_ram_we,
        output qdu_ram_do,
        output e_conv
    );

    modport master (
        output s_conv,
        output dctdu_ram_di,
        input  dctdu_ram_ar,
        input  qdu_ram_aw,
        input  qdu_ram_we,
        input  qdu_ram_do,
        input  e_conv
    );

endinterface

// File: rtl/jpeg_enc_qtab.sv
// Combinational reciprocal ROM: R = round(65536/Q[n]) for the luma or chroma table.
module jpeg_enc_qtab
    import jpeg_enc_quant_pkg::*;
(
    input  logic                i_chroma,
    input  logic [IDX_W-1:0]    i_idx,
    output logic [RECIP_W-1:0]  o_recip
);

    logic [RECIP_W-1:0] w_luma   [64];
    logic [RECIP_W-1:0] w_chroma [64];

    for (genvar n = 0; n < 64; n++) begin : g_rom
        localparam logic [RECIP_W-1:0] RLuma   = recip_of(Q_LUMA[n]);
        localparam logic [RECIP_W-1:0] RChroma = recip_of(Q_CHROMA[n]);
        assign w_luma[n]   = RLuma;
        assign w_chroma[n] = RChroma;
    end

    assign o_recip = i_chroma ? w_chroma[i_idx] : w_luma[i_idx];

endmodule

// File: rtl/jpeg_enc_quant.sv
// JPEG quantizer: reads a DCT block in zigzag order, multiplies by the table reciprocal with
// rounding and saturation, and writes the result to qdu RAM at the zigzag position.
module jpeg_enc_quant
    import jpeg_enc_quant_pkg::*;
#(
    parameter bit CHROMA = 1'b0
) (
    input  logic              clk,
    input  logic              reset_n,
    jpeg_enc_quant_if.slave   io_q
);

    state_e                    r_state;
    state_e                    w_state_nxt;
    logic [IDX_W-1:0]          r_cnt;
    logic [IDX_W-1:0]          w_cnt_nxt;

    logic                      r_v2;
    logic                      r_v3;
    logic                      r_we;
    logic [IDX_W-1:0]          r_idx2;
    logic [IDX_W-1:0]          r_idx3;
    logic [IDX_W-1:0]          r_pos2;
    logic [IDX_W-1:0]          r_pos3;
    logic [IDX_W-1:0]          r_aw;
    logic signed [COEF_W-1:0]  r_coef;
    logic signed [QOUT_W-1:0]  r_do;

    logic                      w_run;
    logic [IDX_W-1:0]          w_ar;
    logic [RECIP_W-1:0]        w_recip;
    logic [COEF_W-2:0]         w_mag;
    logic [33:0]               w_prod;
    logic [17:0]               w_qmag;
    logic [QOUT_W-1:0]         w_qext;
    logic [QOUT_W-1:0]         w_q;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StIdle;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            StIdle: begin
                w_cnt_nxt = '0;
                if (io_q.s_conv) w_state_nxt = StRun;
            end
            StRun: begin
                // Wraps to 0 after the 64th read, leaving the counter clean for the next block.
                w_cnt_nxt = r_cnt + 6'd1;
                if (r_cnt == 6'd63) w_state_nxt = StDrain;
            end
            StDrain: begin
                if (r_we && (r_aw == 6'd63)) w_state_nxt = StExit;
            end
            StExit: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign w_run = (r_state == StRun);
    assign w_ar  = w_run ? ZZ[r_cnt] : '0;

    // ---------------- Datapath ----------------
    jpeg_enc_qtab u_qtab (
        .i_chroma (CHROMA),
        .i_idx    (r_idx3),
        .o_recip  (w_recip)
    );

    always_comb begin
        if (r_coef == 18'sh20000) begin
            w_mag = 17'h1ffff;
        end else if (r_coef[COEF_W-1]) begin
            w_mag = 17'(18'd0 - r_coef);
        end else begin
            w_mag = r_coef[COEF_W-2:0];
        end
        w_prod = 34'(w_mag) * 34'(w_recip) + 34'd32768;
        w_qmag = 18'(w_prod >> 16);
        w_qext = (w_qmag > 18'(QMAX)) ? 12'(QMAX) : {1'b0, w_qmag[10:0]};
        w_q    = r_coef[COEF_W-1] ? (12'd0 - w_qext) : w_qext;
    end

    // Stage 2 tracks the RAM read latency; stage 3 holds the coefficient; stage 4 is the write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_v2   <= 1'b0;
            r_v3   <= 1'b0;
            r_we   <= 1'b0;
            r_idx2 <= '0;
            r_idx3 <= '0;
            r_pos2 <= '0;
            r_pos3 <= '0;
            r_aw   <= '0;
            r_coef <= '0;
            r_do   <= '0;
        end else begin
            r_v2 <= w_run;
            if (w_run) begin
                r_idx2 <= w_ar;
                r_pos2 <= r_cnt;
            end
            r_v3 <= r_v2;
            if (r_v2) begin
                r_coef <= io_q.dctdu_ram_di;
                r_idx3 <= r_idx2;
                r_pos3 <= r_pos2;
            end
            r_we <= r_v3;
            if (r_v3) begin
                r_aw <= r_pos3;
                r_do <= w_q;
            end
        end
    end

    assign io_q.dctdu_ram_ar = w_ar;
    assign io_q.qdu_ram_aw   = r_aw;
    assign io_q.qdu_ram_we   = r_we;
    assign io_q.qdu_ram_do   = r_do;
    assign io_q.e_conv       = (r_state == StExit);

endmodule
